// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude add/subtract pipeline.
// Operands are packed as {sign, magnitude}; the helpers take the magnitude
// width at the call site so one package serves every MAG_W.
package sm_pkg;

    // Widest operand the field helpers can handle (MAG_W + 1 <= SM_MAX_W).
    localparam int unsigned SM_MAX_W = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } sm_op_e;

    // Sign bit of a {sign, mag} operand zero-extended to SM_MAX_W bits.
    function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v,
                                     input int unsigned         mag_w);
        logic [SM_MAX_W-1:0] sh;
        sh = v >> mag_w;
        return sh[0];
    endfunction

    // Magnitude field of a {sign, mag} operand, returned zero-extended.
    function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v,
                                                   input int unsigned         mag_w);
        logic [SM_MAX_W-1:0] mask;
        mask = (SM_MAX_W'(1) << mag_w) - SM_MAX_W'(1);
        return v & mask;
    endfunction

endpackage

// File: rtl/sm_core.sv
// Stage-2 datapath: combines two sign-magnitude operands whose B sign has
// already had the add/subtract select folded in. Purely combinational.
module sm_core #(
    parameter int unsigned MAG_W = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic             a_sign_i,
    input  logic             b_sign_i,
    input  logic [MAG_W-1:0] ma_i,
    input  logic [MAG_W-1:0] mb_i,
    input  logic             mag_ge_i,
    output logic [MAG_W+1:0] res_o,
    output logic             ovf_o
);

    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] diff_ab;
    logic [MAG_W-1:0] diff_ba;
    logic [MAG_W:0]   mag;
    logic             sign;

    assign sum     = {1'b0, ma_i} + {1'b0, mb_i};
    assign diff_ab = ma_i - mb_i;
    assign diff_ba = mb_i - ma_i;

    // Select magnitude/sign by effective signs, normalise -0, then clamp.
    always_comb begin
        mag   = '0;
        sign  = 1'b0;
        ovf_o = 1'b0;
        if (a_sign_i == b_sign_i) begin
            mag  = sum;
            sign = a_sign_i;
        end else if (mag_ge_i) begin
            mag  = {1'b0, diff_ab};
            sign = a_sign_i;
        end else begin
            mag  = {1'b0, diff_ba};
            sign = b_sign_i;
        end
        if (mag == '0) begin
            sign = 1'b0;
        end
        if ((SAT != 0) && mag[MAG_W]) begin
            mag   = {1'b0, {MAG_W{1'b1}}};
            ovf_o = 1'b1;
        end
        res_o = {sign, mag};
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready on both sides.
// Stage 1 splits operands and pre-compares magnitudes; stage 2 registers the
// combined result. Holds up to two transactions under backpressure.
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int unsigned MAG_W = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W:0]   a,
    input  logic [MAG_W:0]   b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W+1:0] res,
    output logic             ovf
);

    logic             s2_adv;
    logic             s1_adv;

    logic             s1_a_sign_d;
    logic             s1_b_sign_d;
    logic [MAG_W-1:0] s1_ma_d;
    logic [MAG_W-1:0] s1_mb_d;
    logic             s1_ge_d;

    logic             s1_v_q;
    logic             s1_a_sign_q;
    logic             s1_b_sign_q;
    logic [MAG_W-1:0] s1_ma_q;
    logic [MAG_W-1:0] s1_mb_q;
    logic             s1_ge_q;

    logic [MAG_W+1:0] s2_res_d;
    logic             s2_ovf_d;

    logic             s2_v_q;
    logic [MAG_W+1:0] res_q;
    logic             ovf_q;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    // Operand split; subtraction is folded into B's effective sign.
    always_comb begin
        s1_a_sign_d = sm_sign(SM_MAX_W'(a), MAG_W);
        s1_b_sign_d = sm_sign(SM_MAX_W'(b), MAG_W) ^ (op == OP_SUB);
        s1_ma_d     = MAG_W'(sm_mag(SM_MAX_W'(a), MAG_W));
        s1_mb_d     = MAG_W'(sm_mag(SM_MAX_W'(b), MAG_W));
        s1_ge_d     = (s1_ma_d >= s1_mb_d);
    end

    // Stage 1 register: captures a new operand pair whenever it can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_ge_q     <= 1'b0;
        end else if (s1_adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_a_sign_q <= s1_a_sign_d;
                s1_b_sign_q <= s1_b_sign_d;
                s1_ma_q     <= s1_ma_d;
                s1_mb_q     <= s1_mb_d;
                s1_ge_q     <= s1_ge_d;
            end
        end
    end

    sm_core #(
        .MAG_W (MAG_W),
        .SAT   (SAT)
    ) u_core (
        .a_sign_i (s1_a_sign_q),
        .b_sign_i (s1_b_sign_q),
        .ma_i     (s1_ma_q),
        .mb_i     (s1_mb_q),
        .mag_ge_i (s1_ge_q),
        .res_o    (s2_res_d),
        .ovf_o    (s2_ovf_d)
    );

    // Stage 2 register: result holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                res_q <= s2_res_d;
                ovf_q <= s2_ovf_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign res       = res_q;
    assign ovf       = (SAT != 0) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Bench for sm_addsub_pipe: one exact (SAT=0) and one saturating (SAT=1)
// instance share stimulus; a scoreboard per instance checks every output
// against a signed-integer reference model.
module tb_sm_addsub_pipe;
    import sm_pkg::*;

    localparam int MW = 4;

    typedef struct packed {
        logic          ovf;
        logic [MW+1:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          op;
    logic          out_ready;
    logic [MW:0]   a;
    logic [MW:0]   b;
    logic          in_ready0, in_ready1;
    logic          out_valid0, out_valid1;
    logic          ovf0, ovf1;
    logic [MW+1:0] res0, res1;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    sm_addsub_pipe #(.MAG_W(MW), .SAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
        .res(res0), .ovf(ovf0)
    );

    sm_addsub_pipe #(.MAG_W(MW), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .res(res1), .ovf(ovf1)
    );

    // Reference: treat operands as signed integers and rebuild sign-magnitude.
    function automatic exp_t ref_model(input logic [MW:0] x, input logic [MW:0] y,
                                       input logic o, input bit sat);
        int   ma, mb, va, vb, r, m;
        int   lim;
        exp_t e;
        lim = (1 << MW) - 1;
        ma  = int'(x[MW-1:0]);
        mb  = int'(y[MW-1:0]);
        va  = x[MW] ? -ma : ma;
        vb  = y[MW] ? -mb : mb;
        r   = (o == OP_SUB) ? va - vb : va + vb;
        m   = (r < 0) ? -r : r;
        e.ovf = 1'b0;
        if (sat && m > lim) begin
            m     = lim;
            e.ovf = 1'b1;
        end
        e.res = {(r < 0), (MW+1)'(m)};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on output transfer, push on input transfer.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out0: got res %0h expected no output", res0);
            end else begin
                e = q0.pop_front();
                chk("sb_res0", 32'(res0), 32'(e.res));
                chk("sb_ovf0", 32'(ovf0), 32'(e.ovf));
            end
        end
        if (rst_n && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out1: got res %0h expected no output", res1);
            end else begin
                e = q1.pop_front();
                chk("sb_res1", 32'(res1), 32'(e.res));
                chk("sb_ovf1", 32'(ovf1), 32'(e.ovf));
            end
        end
        if (rst_n && in_valid && in_ready0) q0.push_back(ref_model(a, b, op, 1'b0));
        if (rst_n && in_valid && in_ready1) q1.push_back(ref_model(a, b, op, 1'b1));
    end

    // Offer one transaction, entered and left at posedge+1.
    task automatic send(input logic [MW:0] ta, input logic [MW:0] tb, input logic to);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = to;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready low expected accept within 100 cycles");
        end
    endtask

    // Single unstalled transaction with literal expectations and latency check.
    task automatic dir(input string nm, input logic [MW:0] ta, input logic [MW:0] tb,
                       input logic to, input logic [MW+1:0] e0, input logic o0,
                       input logic [MW+1:0] e1, input logic o1);
        out_ready = 1'b1;
        send(ta, tb, to);
        chk({nm, "_early"}, 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_valid0"}, 32'(out_valid0), 32'd1);
        chk({nm, "_valid1"}, 32'(out_valid1), 32'd1);
        chk({nm, "_res0"},   32'(res0), 32'(e0));
        chk({nm, "_ovf0"},   32'(ovf0), 32'(o0));
        chk({nm, "_res1"},   32'(res1), 32'(e1));
        chk({nm, "_ovf1"},   32'(ovf1), 32'(o1));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got still running expected finish");
        $fatal(1);
    end

    initial begin : driver
        logic [MW:0] sa[4];
        logic [MW:0] sb[4];
        logic        so[4];
        exp_t        hold0, hold1;
        int          idx, acc;
        bit          acc_now, rnd_done;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_res0",   32'(res0), 32'd0);
        chk("rst_ovf1",   32'(ovf1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready0", 32'(in_ready0), 32'd1);
        chk("rst_ready1", 32'(in_ready1), 32'd1);

        dir("p5p3",    5'b0_0101, 5'b0_0011, OP_ADD, 6'b0_01000, 1'b0, 6'b0_01000, 1'b0);
        dir("p3m5",    5'b0_0011, 5'b0_0101, OP_SUB, 6'b1_00010, 1'b0, 6'b1_00010, 1'b0);
        dir("m7p7",    5'b1_0111, 5'b0_0111, OP_ADD, 6'b0_00000, 1'b0, 6'b0_00000, 1'b0);
        dir("negzero", 5'b1_0000, 5'b0_0000, OP_SUB, 6'b0_00000, 1'b0, 6'b0_00000, 1'b0);
        dir("p15mm1",  5'b0_1111, 5'b1_0001, OP_SUB, 6'b0_10000, 1'b0, 6'b0_01111, 1'b1);
        dir("p15p15",  5'b0_1111, 5'b0_1111, OP_ADD, 6'b0_11110, 1'b0, 6'b0_01111, 1'b1);
        dir("m15m1",   5'b1_1111, 5'b0_0001, OP_SUB, 6'b1_10000, 1'b0, 6'b1_01111, 1'b1);

        // Backpressure: stream of 4 into a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            sa[i] = (MW+1)'($urandom);
            sb[i] = (MW+1)'($urandom);
            so[i] = 1'($urandom);
        end
        hold0 = ref_model(sa[0], sb[0], so[0], 1'b0);
        hold1 = ref_model(sa[0], sb[0], so[0], 1'b1);
        out_ready = 1'b0;
        idx = 0; acc = 0;
        in_valid = 1'b1; a = sa[0]; b = sb[0]; op = so[0];
        for (int c = 0; c < 10; c++) begin
            if (c == 6) begin
                chk("stall_accepted", 32'(acc), 32'd2);
                chk("stall_ready0", 32'(in_ready0), 32'd0);
                chk("stall_ready1", 32'(in_ready1), 32'd0);
                out_ready = 1'b1;
            end
            @(negedge clk);
            acc_now = in_valid && in_ready0;
            if (acc_now) acc++;
            if (c >= 2 && c < 6) begin
                chk("stall_valid", 32'(out_valid0), 32'd1);
                chk("stall_res0", 32'(res0), 32'(hold0.res));
                chk("stall_res1", 32'(res1), 32'(hold1.res));
            end
            if (c >= 6) chk("b2b_valid", 32'(out_valid0), 32'd1);
            @(posedge clk);
            #1;
            if (acc_now) begin
                idx++;
                if (idx < 4) begin
                    a = sa[idx]; b = sb[idx]; op = so[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("b2b_empty", 32'(out_valid0), 32'd0);
        chk("b2b_total", 32'(acc), 32'd4);
        @(posedge clk);
        #1;

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        send(5'b0_0110, 5'b0_0001, OP_ADD);
        send(5'b1_0010, 5'b0_0100, OP_SUB);
        chk("full_valid", 32'(out_valid0), 32'd1);
        chk("full_ready", 32'(in_ready0), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid0", 32'(out_valid0), 32'd0);
        chk("arst_valid1", 32'(out_valid1), 32'd0);
        chk("arst_res0",   32'(res0), 32'd0);
        chk("arst_res1",   32'(res1), 32'd0);
        chk("arst_ovf1",   32'(ovf1), 32'd0);
        q0.delete();
        q1.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("arst_ready", 32'(in_ready0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_stale0", 32'(out_valid0), 32'd0);
            chk("arst_stale1", 32'(out_valid1), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send((MW+1)'($urandom), (MW+1)'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
- Parametrised sign-magnitude (Q-format) adder/subtractor with a 2-stage pipeline and valid/ready handshakes on both sides.
- Successor to the fixed 5-bit registered adder. Adds:
  - generic magnitude width
  - per-transaction add/subtract select
  - correct mixed-sign arithmetic
  - negative-zero normalisation
  - optional saturation with an overflow flag
  - backpressure
- Sits between operand producers and downstream Q-format datapath stages.

Parameters:
- MAG_W, 4: magnitude bits per operand; operands are MAG_W+1 bits {sign, mag}.
- SAT, 0: 0 = exact result (MAG_W+1 magnitude bits); 1 = clamp magnitude to 2^MAG_W-1 and assert ovf.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock domain only.
- in_valid  in  1  operand pair and op valid.
- in_ready  out  1  block can accept this cycle.
- a  in  MAG_W+1  operand A {sign, magnitude}.
- b  in  MAG_W+1  operand B {sign, magnitude}.
- op  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  res/ovf valid.
- out_ready  in  1  consumer accepts this cycle.
- res  out  MAG_W+2  result {sign, magnitude[MAG_W:0]}.
- ovf  out  1  SAT=1 only: true magnitude exceeded 2^MAG_W-1; tied 0 when SAT=0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, res = 0, ovf = 0, out_valid = 0. In-flight data is discarded. in_ready = 1 from the first cycle after rst_n deasserts.
- Handshakes:
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - s2_adv = !s2_v | out_ready.
  - s1_adv = !s1_v | s2_adv.
  - in_ready = s1_adv (combinational, no in_valid dependency).
- Stage 1 registers: a_sign, effective b sign (b_sign ^ op), both magnitudes, and mag_ge = (ma >= mb).
- Stage 2 computes and registers res/ovf:
  - Same effective signs: mag = ma + mb (MAG_W+1 bits), sign = a_sign.
  - Differing signs, mag_ge = 1: mag = ma - mb, sign = a_sign.
  - Differing signs, mag_ge = 0: mag = mb - ma, sign = effective b sign.
  - mag == 0 forces sign = 0. Negative-zero inputs are therefore legal and yield +0.
  - SAT=1 and mag[MAG_W] = 1: mag = {0, all ones}, sign kept, ovf = 1. Otherwise ovf = 0.
- Latency: accept in cycle N gives out_valid in cycle N+2 when unstalled. Throughput is 1 per cycle.
- Stall: while out_valid & !out_ready, res/ovf/out_valid hold stable. Stage 1 fills, then in_ready drops. Capacity is 2 transactions. Order is preserved, and nothing is dropped or duplicated.
- Simultaneous accept-in and drain-out with both stages full: legal; all stages advance in the same cycle.
- rst_n asserted mid-stall: out_valid drops immediately (asynchronous). No result is emitted for the pending transactions.

Decomposition:
- Package sm_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Field-extract helper functions sm_sign and sm_mag, parametrised via MAG_W passed at use site.
- Sub-module sm_core: purely combinational stage-2 datapath (sign-select, add/sub, zero normalisation, saturation), parametrised by MAG_W and SAT.
- The pipeline and handshake logic stay in sm_addsub_pipe.

Test Plan:
- MAG_W=4, a=0_0101 (+5), b=0_0011 (+3), op=ADD -> res=6'b0_01000 (+8), ovf=0, out_valid 2 cycles after accept.
- a=0_0011 (+3), b=0_0101 (+5), op=SUB -> res=6'b1_00010 (-2). Then a=1_0111 (-7), b=0_0111 (+7), op=ADD -> res=6'b0_00000 (+0, no negative zero).
- a=1_0000 (-0), b=0_0000 (+0), op=SUB -> res=6'b0_00000. Then a=0_1111, b=1_0001, op=SUB -> res=6'b0_10000 (+16) with SAT=0.
- SAT=1: a=0_1111, b=0_1111, ADD -> res=6'b0_01111, ovf=1. a=1_1111, b=0_0001, SUB -> res=6'b1_01111, ovf=1.
- out_ready=0, in_valid=1 with a stream of 4 transactions:
  - exactly 2 accepted, then in_ready=0;
  - res stable throughout the stall;
  - out_ready=1 -> 4 results in order, back-to-back.
- Fill both stages, pulse rst_n low mid-cycle -> out_valid=0 and res=0 asynchronously; no stale result after release; in_ready=1.
